// File: rtl/hazard_ctrl.sv
// Pipeline hazard/freeze controller: load/RAW interlock, branch squash, memory freeze, halt.
// Optional macro HAZARD_CTRL_FORWARD_EN limits interlock to load-use hazards.
module hazard_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_rs_valid,
  input  logic        id_rt_valid,
  input  logic [2:0]  ex_rd,
  input  logic [2:0]  mem_rd,
  input  logic [2:0]  wb_rd,
  input  logic        ex_regWrite,
  input  logic        mem_regWrite,
  input  logic        wb_regWrite,
  input  logic        ex_mem_to_reg,
  input  logic        br_taken,
  input  logic        mem_req,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_stall,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALTED = 2'd2} state_t;

  state_t     cur, nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic [4:0] en;
  logic       hazard, run_eval;

  function automatic logic hit(input logic [2:0] src, input logic v,
                               input logic [2:0] rd, input logic we);
    return v & we & (src == rd);
  endfunction

`ifdef HAZARD_CTRL_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{mem_rd, wb_rd, mem_regWrite, wb_regWrite};
  assign hazard = ex_mem_to_reg & (hit(id_rs, id_rs_valid, ex_rd, ex_regWrite) |
                                   hit(id_rt, id_rt_valid, ex_rd, ex_regWrite));
`else
  logic unused_fwd;
  assign unused_fwd = ex_mem_to_reg;
  assign hazard = hit(id_rs, id_rs_valid, ex_rd,  ex_regWrite)  |
                  hit(id_rs, id_rs_valid, mem_rd, mem_regWrite) |
                  hit(id_rs, id_rs_valid, wb_rd,  wb_regWrite)  |
                  hit(id_rt, id_rt_valid, ex_rd,  ex_regWrite)  |
                  hit(id_rt, id_rt_valid, mem_rd, mem_regWrite) |
                  hit(id_rt, id_rt_valid, wb_rd,  wb_regWrite);
`endif

  always_comb begin
    en         = '1;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    nxt        = cur;
    wait_nxt   = wait_cnt;
    run_eval   = 1'b0;
    if (!rst) begin
      case (cur)
        HALTED: en = '0;
        MEMWAIT: begin
          if (wait_cnt != 4'd0) begin
            en       = '0;
            wait_nxt = wait_cnt - 4'd1;
          end else begin
            // release cycle: behave as RUN but without re-arming on mem_req
            nxt      = RUN;
            run_eval = 1'b1;
          end
        end
        default: begin
          if (mem_req && (MEM_LAT > 0)) begin
            en       = '0;
            wait_nxt = 4'(MEM_LAT - 1);
            nxt      = MEMWAIT;
          end else begin
            run_eval = 1'b1;
          end
        end
      endcase
      if (run_eval) begin
        if (br_taken) begin
          ifid_flush = 1'b1;
          idex_stall = 1'b1;
        end else if (hazard) begin
          en[4]      = 1'b0;
          en[3]      = 1'b0;
          idex_stall = 1'b1;
        end
      end
      if (cur != HALTED && wb_halt) nxt = HALTED;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
  assign halted = (cur == HALTED);
  assign state  = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      if (!pc_en && cur != HALTED && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MEM_LAT=2).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic        id_rs_valid, id_rt_valid;
  logic        ex_regWrite, mem_regWrite, wb_regWrite, ex_mem_to_reg;
  logic        br_taken, mem_req, wb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_stall, halted;
  logic [1:0]  dut_state;
  logic [15:0] stall_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct packed {
    logic [4:0]  en;
    logic        flush;
    logic        stall;
    logic        halt;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        full;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_regWrite(ex_regWrite), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
    .ex_mem_to_reg(ex_mem_to_reg), .br_taken(br_taken),
    .mem_req(mem_req), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .halted(halted), .state(dut_state), .stall_cnt(stall_cnt)
  );

  // Push expectation, compare at negedge, then advance to just after next posedge.
  task automatic cyc(input string tag, input logic [4:0] en, input logic flush,
                     input logic stall, input logic halt, input logic [1:0] st,
                     input logic full);
    exp_t e;
    logic [4:0] got_en;
    sb.push_back({en, flush, stall, halt, st, exp_cnt, full});
    @(negedge clk);
    e = sb.pop_front();
    got_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    tests++;
    assert (got_en === e.en) else begin
      fails++; $error("FAIL %s enables: got %b expected %b", tag, got_en, e.en);
    end
    tests++;
    assert ({ifid_flush, idex_stall} === {e.flush, e.stall}) else begin
      fails++; $error("FAIL %s flush/stall: got %b%b expected %b%b", tag,
                      ifid_flush, idex_stall, e.flush, e.stall);
    end
    if (e.full) begin
      tests++;
      assert (halted === e.halt) else begin
        fails++; $error("FAIL %s halted: got %b expected %b", tag, halted, e.halt);
      end
      tests++;
      assert (dut_state === e.st) else begin
        fails++; $error("FAIL %s state: got %0d expected %0d", tag, dut_state, e.st);
      end
      tests++;
      assert (stall_cnt === e.cnt) else begin
        fails++; $error("FAIL %s stall_cnt: got %0h expected %0h", tag, stall_cnt, e.cnt);
      end
    end
    if (rst) exp_cnt = '0;
    else if (!en[4] && e.st != 2'd2 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 3'd0; id_rt = 3'd0; id_rs_valid = 1'b0; id_rt_valid = 1'b0;
    ex_rd = 3'd0; mem_rd = 3'd0; wb_rd = 3'd0;
    ex_regWrite = 1'b0; mem_regWrite = 1'b0; wb_regWrite = 1'b0;
    ex_mem_to_reg = 1'b0; br_taken = 1'b0; mem_req = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_hold", 5'b11111, 0, 0, 0, 2'd0, 1);
    rst = 1'b0;
    cyc("normal", 5'b11111, 0, 0, 0, 2'd0, 1);

    // memory freeze, MEM_LAT=2
    mem_req = 1'b1;
    cyc("freeze0", 5'b00000, 0, 0, 0, 2'd0, 1);
    mem_req = 1'b0; br_taken = 1'b1;
    cyc("freeze1_brign", 5'b00000, 0, 0, 0, 2'd1, 1);
    br_taken = 1'b0;
    cyc("release", 5'b11111, 0, 0, 0, 2'd1, 1);
    cyc("after_freeze", 5'b11111, 0, 0, 0, 2'd0, 1);
    // mem_req held: release cycle ignores it, then re-arms
    mem_req = 1'b1;
    cyc("hold_f0", 5'b00000, 0, 0, 0, 2'd0, 1);
    cyc("hold_f1", 5'b00000, 0, 0, 0, 2'd1, 1);
    cyc("hold_rel", 5'b11111, 0, 0, 0, 2'd1, 1);
    cyc("hold_rearm", 5'b00000, 0, 0, 0, 2'd0, 1);
    mem_req = 1'b0;
    cyc("hold_f1b", 5'b00000, 0, 0, 0, 2'd1, 1);
    cyc("hold_relb", 5'b11111, 0, 0, 0, 2'd1, 1);

`ifdef HAZARD_CTRL_FORWARD_EN
    // load-use: one bubble
    ex_rd = 3'd5; ex_regWrite = 1'b1; ex_mem_to_reg = 1'b1; id_rt = 3'd5; id_rt_valid = 1'b1;
    cyc("loaduse", 5'b00111, 0, 1, 0, 2'd0, 1);
    ex_regWrite = 1'b0; ex_mem_to_reg = 1'b0; mem_rd = 3'd5; mem_regWrite = 1'b1;
    cyc("loaduse_adv", 5'b11111, 0, 0, 0, 2'd0, 1);
    idle_inputs();
    ex_rd = 3'd5; ex_regWrite = 1'b1; id_rt = 3'd5; id_rt_valid = 1'b1;
    cyc("alu_fwd", 5'b11111, 0, 0, 0, 2'd0, 1);
    idle_inputs();
`else
    // RAW on r3 propagating EX -> MEM -> WB: three bubbles
    ex_rd = 3'd3; ex_regWrite = 1'b1; id_rs = 3'd3; id_rs_valid = 1'b1;
    cyc("raw_ex", 5'b00111, 0, 1, 0, 2'd0, 1);
    ex_regWrite = 1'b0; mem_rd = 3'd3; mem_regWrite = 1'b1;
    cyc("raw_mem", 5'b00111, 0, 1, 0, 2'd0, 1);
    mem_regWrite = 1'b0; wb_rd = 3'd3; wb_regWrite = 1'b1;
    cyc("raw_wb", 5'b00111, 0, 1, 0, 2'd0, 1);
    wb_regWrite = 1'b0;
    cyc("raw_adv", 5'b11111, 0, 0, 0, 2'd0, 1);
    idle_inputs();
    // r0 is not exempt; invalid source never matches
    wb_rd = 3'd0; wb_regWrite = 1'b1; id_rt = 3'd0; id_rt_valid = 1'b1;
    cyc("r0_hazard", 5'b00111, 0, 1, 0, 2'd0, 1);
    id_rt_valid = 1'b0;
    cyc("invalid_src", 5'b11111, 0, 0, 0, 2'd0, 1);
    idle_inputs();
`endif

    // branch beats a simultaneous load-use hazard
    ex_rd = 3'd2; ex_regWrite = 1'b1; ex_mem_to_reg = 1'b1; id_rs = 3'd2; id_rs_valid = 1'b1;
    br_taken = 1'b1;
    cyc("br_hazard", 5'b11111, 1, 1, 0, 2'd0, 1);
    idle_inputs();

    // halt from RUN
    wb_halt = 1'b1;
    cyc("halt_req", 5'b11111, 0, 0, 0, 2'd0, 1);
    wb_halt = 1'b0; mem_req = 1'b1;
    cyc("halted", 5'b00000, 0, 0, 1, 2'd2, 1);
    cyc("halted2", 5'b00000, 0, 0, 1, 2'd2, 1);
    mem_req = 1'b0; rst = 1'b1;
    cyc("rst_from_halt", 5'b11111, 0, 0, 0, 2'd0, 0);
    rst = 1'b0;
    cyc("post_rst", 5'b11111, 0, 0, 0, 2'd0, 1);

    // halt requested mid-MEMWAIT, then reset out of it
    mem_req = 1'b1;
    cyc("mw_f0", 5'b00000, 0, 0, 0, 2'd0, 1);
    mem_req = 1'b0; wb_halt = 1'b1;
    cyc("mw_halt_req", 5'b00000, 0, 0, 0, 2'd1, 1);
    wb_halt = 1'b0;
    cyc("mw_halted", 5'b00000, 0, 0, 1, 2'd2, 1);
    rst = 1'b1;
    cyc("mw_rst", 5'b11111, 0, 0, 0, 2'd0, 0);
    rst = 1'b0;
    mem_req = 1'b1;
    cyc("rst_mid_f0", 5'b00000, 0, 0, 0, 2'd0, 1);
    mem_req = 1'b0; rst = 1'b1;
    cyc("rst_mid_wait", 5'b11111, 0, 0, 0, 2'd1, 1);
    rst = 1'b0;
    cyc("rst_mid_after", 5'b11111, 0, 0, 0, 2'd0, 1);

    // saturation of stall_cnt under a persistent hazard
    ex_rd = 3'd4; ex_regWrite = 1'b1; ex_mem_to_reg = 1'b1; id_rs = 3'd4; id_rs_valid = 1'b1;
    for (int unsigned i = 0; i < 70000; i++) @(posedge clk);
    #1;
    exp_cnt = 16'hFFFF;
    cyc("sat", 5'b00111, 0, 1, 0, 2'd0, 1);
    cyc("sat_hold", 5'b00111, 0, 1, 0, 2'd0, 1);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MEM_LAT, default 2, data-memory access latency in cycles (0..15); 0 = single-cycle memory, no freeze.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs, id_rt  in  3 each  source registers of the instruction in ID.
REQ-005 id_rs_valid, id_rt_valid  in  1 each  ID instruction reads id_rs / id_rt.
REQ-006 ex_rd, mem_rd, wb_rd  in  3 each  destination register held in ID/EX, EX/MEM, MEM/WB.
REQ-007 ex_regWrite, mem_regWrite, wb_regWrite  in  1 each  write-enable held in ID/EX, EX/MEM, MEM/WB.
REQ-008 ex_mem_to_reg  in  1  instruction in ID/EX is a load.
REQ-009 br_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-010 mem_req  in  1  instruction in MEM accesses data memory.
REQ-011 wb_halt  in  1  halt flag held in MEM/WB.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
REQ-013 ifid_flush  out  1  IF/ID loads NOP; idex_stall  out  1  ID/EX loads bubble (NOP 16'h0800, control bits cleared).
REQ-014 halted  out  1; state  out  2 (RUN=0, MEMWAIT=1, HALTED=2); stall_cnt  out  16.

Function
REQ-015 hazard (no FORWARD_EN) = any valid source matching ex_rd&ex_regWrite, mem_rd&mem_regWrite or wb_rd&wb_regWrite; register 0 is not exempt.
REQ-016 Priority each cycle: HALTED > memory freeze > br_taken > hazard > normal.
REQ-017 RUN, normal: all enables 1, ifid_flush=0, idex_stall=0.
REQ-018 RUN, mem_req=1 and MEM_LAT>0: all enables 0 (freeze), wait_cnt loads MEM_LAT-1, next state MEMWAIT.
REQ-019 MEMWAIT, wait_cnt!=0: all enables 0, wait_cnt decrements; br_taken/hazard ignored.
REQ-020 MEMWAIT, wait_cnt==0: outputs evaluated as RUN with mem_req ignored (release cycle); next state RUN; total freeze = MEM_LAT cycles.
REQ-021 RUN, br_taken: all enables 1, ifid_flush=1, idex_stall=1; hazard ignored (ID instruction squashed).
REQ-022 RUN, hazard: pc_en=0, ifid_en=0, idex_en=1, idex_stall=1, exmem_en=1, memwb_en=1; stall repeats every cycle hazard persists.
REQ-023 wb_halt=1 in RUN or MEMWAIT: next state HALTED; that cycle outputs per lower-priority rules.
REQ-024 HALTED: all enables 0, halted=1; exits only via rst.
REQ-025 stall_cnt increments on each cycle with pc_en=0 while state!=HALTED; saturates at 16'hFFFF.
REQ-026 All outputs except stall_cnt/state are combinational from state, wait_cnt and inputs.

Reset
REQ-027 rst=1 at a clock edge: state=RUN, wait_cnt=0, stall_cnt=0, halted=0, regardless of state (incl. HALTED, mid-MEMWAIT).
REQ-028 While rst=1: all enables 1, ifid_flush=0, idex_stall=0 (downstream registers reset themselves).

Configuration
REQ-029 Macro HAZARD_CTRL_FORWARD_EN defined: hazard = load-use only (ex_mem_to_reg & ex_regWrite & valid source == ex_rd); one bubble per load-use.
REQ-030 Macro undefined: hazard per REQ-015 (full interlock, up to 3 bubbles).

Verification
REQ-031 MEM_LAT=2, mem_req=1 one cycle in RUN -> enables 0 for 2 cycles, state 1 then 0, stall_cnt +2.
REQ-032 No FORWARD_EN, ex_rd=3 ex_regWrite=1, id_rs=3 valid, propagated normally -> 3 consecutive bubbles (idex_stall=1, pc_en=0), then advance.
REQ-033 FORWARD_EN, load to r5 in EX, id_rt=5 valid -> exactly 1 bubble; non-load producer -> 0 bubbles.
REQ-034 br_taken=1 with simultaneous hazard -> ifid_flush=1, idex_stall=1, pc_en=1.
REQ-035 wb_halt=1 -> next cycle halted=1, state=2, enables 0; rst pulse -> state=0, stall_cnt=0.
REQ-036 hazard held 70000 cycles -> stall_cnt stops at 16'hFFFF.
